// File: rtl/nolinear_pwl_stream.sv
// Multi-lane streaming piecewise-linear evaluator (exp / GELU / SiLU / root).
// Four-stage pipeline with one global advance, per-beat mode and runtime-loadable coefficient banks.
module nolinear_pwl_stream #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int Bf              = 8,
    parameter int DATA_NUM        = 4,
    parameter int SEG_BITS        = 4,
    parameter int SEG_SHIFT       = Bf,
    parameter int COEF_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          in_mode,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out,
    input  logic                                cfg_we,
    input  logic [1:0]                          cfg_mode,
    input  logic [SEG_BITS-1:0]                 cfg_addr,
    input  logic [COEF_WIDTH-1:0]               cfg_slope,
    input  logic [COEF_WIDTH-1:0]               cfg_icpt,
    output logic                                busy
);

    localparam int W         = FIX_POINT_WIDTH;
    localparam int P         = COEF_WIDTH + W;
    localparam int NSEG      = 2 ** SEG_BITS;
    localparam int TAB_DEPTH = 4 * NSEG;

    localparam logic signed [W:0] SEG_MID = (W+1)'(NSEG / 2);
    localparam logic signed [W:0] SEG_TOP = (W+1)'(NSEG - 1);
    localparam logic signed [P:0] SAT_MAX = (P+1)'(2 ** (W-1) - 1);
    localparam logic signed [P:0] SAT_MIN = ~SAT_MAX;

    logic [COEF_WIDTH-1:0] slope_tab [TAB_DEPTH];
    logic [COEF_WIDTH-1:0] icpt_tab  [TAB_DEPTH];

    logic       adv;
    logic       s1_valid, s2_valid, s3_valid, s4_valid;
    logic [1:0] s1_mode, s2_mode, s3_mode;

    assign adv       = !s4_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = s4_valid;
    assign busy      = s1_valid || s2_valid || s3_valid || s4_valid;

    // Tables must clear on reset, so they live in registers rather than RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAB_DEPTH; i++) begin
                slope_tab[i] <= '0;
                icpt_tab[i]  <= '0;
            end
        end else if (cfg_we) begin
            slope_tab[{cfg_mode, cfg_addr}] <= cfg_slope;
            icpt_tab[{cfg_mode, cfg_addr}]  <= cfg_icpt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_mode  <= 2'b00;
            s2_mode  <= 2'b00;
            s3_mode  <= 2'b00;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
            s1_mode  <= in_mode;
            s2_mode  <= s1_mode;
            s3_mode  <= s2_mode;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_NUM; gi++) begin : g_lane
            logic signed [W-1:0]          x_in;
            logic signed [W:0]            x_ext;
            logic signed [W:0]            t;
            logic [SEG_BITS-1:0]          seg_c;
            logic                         hi_c, lo_c;
            logic signed [W-1:0]          s1_x, s2_x, s3_x, s4_y;
            logic [SEG_BITS-1:0]          s1_seg;
            logic                         s1_hi, s1_lo, s2_hi, s2_lo, s3_hi, s3_lo;
            logic signed [COEF_WIDTH-1:0] s2_slope, s2_icpt, s3_icpt;
            logic signed [P-1:0]          s3_prod;
            logic signed [P:0]            acc;
            logic signed [W-1:0]          y_c;

            assign x_in  = in[gi*W +: W];
            assign x_ext = {x_in[W-1], x_in};
            assign t     = (x_ext >>> SEG_SHIFT) + SEG_MID;
            assign hi_c  = (t > SEG_TOP);
            assign lo_c  = t[W];
            assign seg_c = lo_c ? '0 : (hi_c ? '1 : t[SEG_BITS-1:0]);

            assign acc = ($signed({s3_prod[P-1], s3_prod}) >>> Bf)
                       + $signed({{(P+1-COEF_WIDTH){s3_icpt[COEF_WIDTH-1]}}, s3_icpt});

            // GELU/SiLU become identity above the table range and zero below it.
            always_comb begin
                if (acc > SAT_MAX)
                    y_c = {1'b0, {(W-1){1'b1}}};
                else if (acc < SAT_MIN)
                    y_c = {1'b1, {(W-1){1'b0}}};
                else
                    y_c = acc[W-1:0];
                if (s3_mode == 2'b01 || s3_mode == 2'b10) begin
                    if (s3_hi)
                        y_c = s3_x;
                    else if (s3_lo)
                        y_c = '0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_x     <= '0;
                    s1_seg   <= '0;
                    s1_hi    <= 1'b0;
                    s1_lo    <= 1'b0;
                    s2_x     <= '0;
                    s2_hi    <= 1'b0;
                    s2_lo    <= 1'b0;
                    s2_slope <= '0;
                    s2_icpt  <= '0;
                    s3_x     <= '0;
                    s3_hi    <= 1'b0;
                    s3_lo    <= 1'b0;
                    s3_icpt  <= '0;
                    s3_prod  <= '0;
                    s4_y     <= '0;
                end else if (adv) begin
                    s1_x     <= x_in;
                    s1_seg   <= seg_c;
                    s1_hi    <= hi_c;
                    s1_lo    <= lo_c;
                    s2_x     <= s1_x;
                    s2_hi    <= s1_hi;
                    s2_lo    <= s1_lo;
                    s2_slope <= slope_tab[{s1_mode, s1_seg}];
                    s2_icpt  <= icpt_tab[{s1_mode, s1_seg}];
                    s3_x     <= s2_x;
                    s3_hi    <= s2_hi;
                    s3_lo    <= s2_lo;
                    s3_icpt  <= s2_icpt;
                    s3_prod  <= s2_slope * s2_x;
                    s4_y     <= y_c;
                end
            end

            assign out[gi*W +: W] = s4_y;
        end
    endgenerate

endmodule

// File: tb/tb_nolinear_pwl_stream.sv
// Directed bench for nolinear_pwl_stream: reset, evaluation, bypass, saturation, backpressure, races.
module tb_nolinear_pwl_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_slope = '0;
    logic [15:0] cfg_icpt = '0;
    logic        busy;

    int check_cnt = 0;
    int pass_cnt  = 0;

    nolinear_pwl_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .cfg_addr  (cfg_addr),
        .cfg_slope (cfg_slope),
        .cfg_icpt  (cfg_icpt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [1:0] m, input logic [3:0] a,
                             input logic [15:0] s, input logic [15:0] ic);
        @(negedge clk);
        cfg_we = 1'b1; cfg_mode = m; cfg_addr = a; cfg_slope = s; cfg_icpt = ic;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends one beat into an idle pipe and returns its result and edge latency (-1 on timeout).
    task automatic run_beat(input logic [1:0] m, input logic [63:0] d,
                            output logic [63:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 12);
        if (!out_valid) lat = -1;
        res = out_data;
    endtask

    function automatic logic [63:0] bp_vec(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(16 * (k + 1) + i);
        return v;
    endfunction

    function automatic logic [63:0] bp_exp(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            if (k % 2 == 0) v[i*16 +: 16] = 16'(16 * (k + 1) + i + 1);
            else            v[i*16 +: 16] = 16'(2 * (16 * (k + 1) + i));
        end
        return v;
    endfunction

    task automatic test_reset;
        logic [63:0] r;
        int lat;
        #1 rst = 1'b0;
        in_valid = 1'b1; in_mode = 2'b01; in_data = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(negedge clk);
        #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (out_data !== 64'h0) $display("FAIL reset_out: got %h expected 0", out_data);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy);
        else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_beat(2'b00, {4{16'h0300}}, r, lat);
        check_cnt++;
        if (r !== 64'h0) $display("FAIL reset_zero_table: got %h expected 0", r);
        else pass_cnt++;
        $display("test_reset: zero-table result %h", r);
    endtask

    task automatic test_basic;
        logic [63:0] r;
        int lat;
        cfg_write(2'b01, 4'd9, 16'h0080, 16'h0040);
        run_beat(2'b01, {4{16'h0100}}, r, lat);
        check_cnt++;
        if (r !== {4{16'h00C0}}) $display("FAIL basic_value: got %h expected %h", r, {4{16'h00C0}});
        else pass_cnt++;
        check_cnt++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat);
        else pass_cnt++;
        $display("test_basic: out %h latency %0d", r, lat);
    endtask

    task automatic test_gelu_bypass;
        logic [63:0] r;
        logic [63:0] e;
        int lat;
        e = {16'hF810, 16'h0800, 16'h0000, 16'h0900};
        cfg_write(2'b01, 4'd0, 16'h0100, 16'h0010);
        run_beat(2'b01, {16'hF800, 16'h0800, 16'hF700, 16'h0900}, r, lat);
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (r[i*16 +: 16] !== e[i*16 +: 16])
                $display("FAIL gelu_lane%0d: got %h expected %h", i, r[i*16 +: 16], e[i*16 +: 16]);
            else pass_cnt++;
        end
        $display("test_gelu_bypass: out %h", r);
    endtask

    task automatic test_saturation;
        logic [63:0] r;
        int lat;
        cfg_write(2'b00, 4'd15, 16'h7FFF, 16'h7FFF);
        run_beat(2'b00, {4{16'h07FF}}, r, lat);
        check_cnt++;
        if (r !== {4{16'h7FFF}}) $display("FAIL sat_high: got %h expected %h", r, {4{16'h7FFF}});
        else pass_cnt++;
        $display("test_saturation: high %h", r);
        cfg_write(2'b00, 4'd15, 16'h8000, 16'h8000);
        run_beat(2'b00, {4{16'h07FF}}, r, lat);
        check_cnt++;
        if (r !== {4{16'h8000}}) $display("FAIL sat_low: got %h expected %h", r, {4{16'h8000}});
        else pass_cnt++;
        $display("test_saturation: low %h", r);
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int recv = 0;
        cfg_write(2'b00, 4'd8, 16'h0100, 16'h0001);
        cfg_write(2'b01, 4'd8, 16'h0200, 16'h0000);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_mode  = 2'(sent % 2);
                in_data  = bp_vec(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check_cnt++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %0b expected 0", c, in_ready);
                else pass_cnt++;
            end
            if (out_valid && out_ready) begin
                check_cnt++;
                if (recv >= 8)
                    $display("FAIL bp_extra_beat: got %h expected no beat", out_data);
                else if (out_data !== bp_exp(recv))
                    $display("FAIL bp_beat%0d: got %h expected %h", recv, out_data, bp_exp(recv));
                else pass_cnt++;
                $display("test_backpressure: beat %0d out %h", recv, out_data);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_cnt++;
        if (recv !== 8) $display("FAIL bp_count: got %0d expected 8", recv);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL bp_busy_drained: got %0b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_race;
        logic [63:0] got [2];
        int n = 0;
        got[0] = '0;
        got[1] = '0;
        cfg_write(2'b11, 4'd8, 16'h0000, 16'h0011);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b11; in_data = {4{16'h0010}}; out_ready = 1'b1;
        @(negedge clk);
        cfg_we = 1'b1; cfg_mode = 2'b11; cfg_addr = 4'd8; cfg_slope = 16'h0000; cfg_icpt = 16'h0022;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && n < 2) begin
                got[n] = out_data;
                n++;
            end
            @(negedge clk);
        end
        check_cnt++;
        if (got[0] !== {4{16'h0011}}) $display("FAIL race_old: got %h expected %h", got[0], {4{16'h0011}});
        else pass_cnt++;
        check_cnt++;
        if (got[1] !== {4{16'h0022}}) $display("FAIL race_new: got %h expected %h", got[1], {4{16'h0022}});
        else pass_cnt++;
        $display("test_race: first %h second %h", got[0], got[1]);
    endtask

    task automatic test_reset_midflight;
        logic [63:0] r;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b00; in_data = {4{16'h07FF}}; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL mid_out_valid_before: got %0b expected 1", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before: got %0b expected 1", busy);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL mid_out_valid_after: got %0b expected 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL mid_busy_after: got %0b expected 0", busy);
        else pass_cnt++;
        check_cnt++;
        if (out_data !== 64'h0) $display("FAIL mid_out_after: got %h expected 0", out_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        run_beat(2'b01, {4{16'h0100}}, r, lat);
        check_cnt++;
        if (r !== 64'h0) $display("FAIL mid_table_gelu_zeroed: got %h expected 0", r);
        else pass_cnt++;
        run_beat(2'b00, {4{16'h07FF}}, r, lat);
        check_cnt++;
        if (r !== 64'h0) $display("FAIL mid_table_exp_zeroed: got %h expected 0", r);
        else pass_cnt++;
        $display("test_reset_midflight: post-reset out %h", r);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gelu_bypass();
        test_saturation();
        test_backpressure();
        test_race();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
